// File: rtl/misr_window_ctrl_pkg.sv
// Shared types and defaults for the MISR signature-capture window controller.
package misr_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RESET = 3'd1,
    RUN   = 3'd2,
    CMP   = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int DEF_SIG_W   = 1614;
  localparam int DEF_WIN_LEN = 124;
  localparam int DEF_RST_CYC = 1;
  localparam int DEF_CNT_W   = 8;

  // Widest signature sig_eq accepts; callers zero-extend into it.
  localparam int SIG_MAX_W = 2048;

  function automatic logic sig_eq(input logic [SIG_MAX_W-1:0] a,
                                  input logic [SIG_MAX_W-1:0] b);
    return a == b;
  endfunction

endpackage

// File: rtl/misr_window_ctrl_if.sv
// Harness-side bundle for the MISR window controller; clk/rst stay outside.
interface misr_window_ctrl_if #(
  parameter int SIG_W = 1614,
  parameter int CNT_W = 8
) ();

  logic                  ena;
  logic                  start;
  logic [SIG_W-1:0]      golden_sig;
  logic [SIG_W-1:0]      misr_sig;
  logic                  qed_consistent;
  logic                  MISRreset;
  logic                  busy;
  logic                  done;
  logic                  sig_match;
  logic                  qed_fail;
  logic [SIG_W-1:0]      captured_sig;
  logic [CNT_W-1:0]      win_cnt;
  misr_ctrl_pkg::state_t state;

  // start is a request taken only while busy is low (IDLE); there is no
  // ready back-pressure beyond busy, and done pulses once per accepted start.
  modport master (
    output ena, start, golden_sig, misr_sig, qed_consistent,
    input  MISRreset, busy, done, sig_match, qed_fail, captured_sig, win_cnt, state
  );

  modport slave (
    input  ena, start, golden_sig, misr_sig, qed_consistent,
    output MISRreset, busy, done, sig_match, qed_fail, captured_sig, win_cnt, state
  );

endinterface

// File: rtl/misr_window_ctrl_counter.sv
// Saturating up-counter with clear/enable and a flag on the last count before LIMIT.
module misr_win_counter #(
  parameter int CNT_W = 8,
  parameter int LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  localparam logic [CNT_W-1:0] TOP  = CNT_W'(LIMIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && (cnt != TOP)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // tc means the next enabled cycle brings the count to LIMIT.
  assign tc = (cnt == LAST);

endmodule

// File: rtl/misr_window_ctrl.sv
// MISR capture window: pulse MISRreset, count ena cycles, latch and compare signature.
module misr_window_ctrl
  import misr_ctrl_pkg::*;
#(
  parameter int SIG_W   = DEF_SIG_W,
  parameter int WIN_LEN = DEF_WIN_LEN,
  parameter int RST_CYC = DEF_RST_CYC,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  misr_window_ctrl_if.slave  bus
);

  state_t           state;
  logic [SIG_W-1:0] golden_q;
  logic [SIG_W-1:0] captured_q;
  logic             misr_reset_q;
  logic             busy_q;
  logic             done_q;
  logic             match_q;
  logic             qfail_q;

  logic             accept;
  logic             win_en;
  logic             win_tc;
  logic             rst_en;
  logic             rst_tc;
  logic [CNT_W-1:0] win_cnt_q;
  logic [CNT_W-1:0] rst_cnt_unused;

  assign accept = (state == IDLE) && bus.start;
  assign win_en = (state == RUN) && bus.ena;
  assign rst_en = (state == RESET);

  misr_win_counter #(.CNT_W(CNT_W), .LIMIT(WIN_LEN)) u_win_cnt (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (win_en),
    .cnt (win_cnt_q),
    .tc  (win_tc)
  );

  misr_win_counter #(.CNT_W(CNT_W), .LIMIT(RST_CYC)) u_rst_cnt (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (rst_en),
    .cnt (rst_cnt_unused),
    .tc  (rst_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      golden_q     <= '0;
      captured_q   <= '0;
      misr_reset_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      match_q      <= 1'b0;
      qfail_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state        <= RESET;
            golden_q     <= bus.golden_sig;
            captured_q   <= '0;
            match_q      <= 1'b0;
            qfail_q      <= 1'b0;
            misr_reset_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        RESET: begin
          if (rst_tc) begin
            state        <= RUN;
            misr_reset_q <= 1'b0;
          end
        end
        RUN: begin
          if (!bus.qed_consistent) qfail_q <= 1'b1;
          // Capture on the edge that ends the WIN_LEN-th enabled cycle.
          if (bus.ena && win_tc) begin
            captured_q <= bus.misr_sig;
            state      <= CMP;
          end
        end
        CMP: begin
          match_q <= sig_eq(SIG_MAX_W'(captured_q), SIG_MAX_W'(golden_q));
          done_q  <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state        <= IDLE;
          misr_reset_q <= 1'b0;
          busy_q       <= 1'b0;
          done_q       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.MISRreset    = misr_reset_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.sig_match    = match_q;
  assign bus.qed_fail     = qfail_q;
  assign bus.captured_sig = captured_q;
  assign bus.win_cnt      = win_cnt_q;
  assign bus.state        = state;

endmodule
